// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the NPC core
package npc_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NPC_RESET_PC = 32'h8000_0000;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} ifu_state_t;
endpackage

// File: rtl/ifu.sv
// ifu: owns the PC, fetches one instruction at a time and hands inst/pc to decode
module ifu
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = NPC_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  output logic            imem_resp_ready,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  ifu_state_t      state;
  logic [XLEN-1:0] fetch_pc;
  logic            squash;
  logic [XLEN-1:0] target;
  logic            take;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign take = state == WAIT && imem_resp_valid && !squash && !redirect_valid;
  assign imem_req_valid = rst && state == REQ && !redirect_valid;
  assign imem_req_addr = fetch_pc;
  assign imem_resp_ready = state == WAIT;
  assign inst_valid = state == HOLD;
  // fetch FSM: a redirect always wins the PC mux; a redirect in WAIT marks the pending response stale
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      squash   <= 1'b0;
      inst     <= '0;
      pc       <= '0;
    end else begin
      fetch_pc <= redirect_valid ? target : take ? fetch_pc + 32'd4 : fetch_pc;
      if (take) begin
        inst <= imem_resp_data;
        pc   <= fetch_pc;
      end
      case (state)
        REQ:  if (imem_req_valid && imem_req_ready) state <= WAIT;
        WAIT: if (imem_resp_valid) begin
                squash <= 1'b0;
                state  <= take ? HOLD : REQ;
              end else if (redirect_valid) squash <= 1'b1;
        HOLD: if (inst_ready || redirect_valid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for ifu with a configurable stall/latency memory model
module tb_ifu;
  import npc_pkg::*;
  localparam logic [31:0] R = 32'h8000_0000;
  logic        clk = 0, rst = 0;
  logic        imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 0, imem_resp_ready;
  logic [31:0] imem_resp_data = 0;
  logic        inst_valid, inst_ready = 0;
  logic [31:0] inst, pc;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  int tests = 0, fails = 0, cyc = 0, req_cyc = 0, rel_cyc = 0;
  logic [31:0] exp_req[$], exp_pc[$];
  int fire_cyc[$];
  logic        mem_busy = 0;
  logic [31:0] mem_addr = 0;
  int mem_cnt = 0, resp_delay = 0, stall_left = 0;
  logic        prev_stall = 0;
  logic [31:0] prev_addr = 0, e;

  ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // scoreboard and request-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      tests++;
      req_cyc = cyc;
      if (exp_req.size() == 0) begin
        fails++;
        $display("FAIL req_addr: unexpected request to %h", imem_req_addr);
      end else begin
        e = exp_req.pop_front();
        if (imem_req_addr !== e) begin
          fails++;
          $display("FAIL req_addr: got %h expected %h", imem_req_addr, e);
        end
      end
    end
    if (prev_stall && rst && !redirect_valid) begin
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
        fails++;
        $display("FAIL req_hold: valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, prev_addr);
      end
    end
    prev_stall = imem_req_valid && !imem_req_ready;
    prev_addr  = imem_req_addr;
    if (inst_valid && inst_ready) begin
      tests++;
      fire_cyc.push_back(cyc);
      if (exp_pc.size() == 0) begin
        fails++;
        $display("FAIL inst_xfer: unexpected transfer pc=%h inst=%h", pc, inst);
      end else begin
        e = exp_pc.pop_front();
        if (pc !== e || inst !== memf(e)) begin
          fails++;
          $display("FAIL inst_xfer: got pc=%h inst=%h expected pc=%h inst=%h", pc, inst, e, memf(e));
        end
      end
    end
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic drive_mem();
    imem_req_ready  = stall_left == 0;
    imem_resp_valid = mem_busy && mem_cnt == 0;
    imem_resp_data  = mem_busy ? memf(mem_addr) : 32'h0;
  endtask

  task automatic step();
    logic rq, rs, rv;
    logic [31:0] ra;
    #1;
    rq = imem_req_valid && imem_req_ready;
    rs = imem_resp_valid && imem_resp_ready;
    rv = imem_req_valid;
    ra = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (rq) begin
      mem_busy = 1;
      mem_addr = ra;
      mem_cnt  = resp_delay;
    end else if (rs) mem_busy = 0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (rv && !rq && stall_left > 0) stall_left--;
    drive_mem();
  endtask

  task automatic do_reset(input int stall, input int delay);
    rst = 0;
    redirect_valid = 0;
    inst_ready = 0;
    mem_busy = 0;
    stall_left = stall;
    resp_delay = delay;
    drive_mem();
    step();
    step();
    fire_cyc.delete();
    rst = 1;
    rel_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((exp_req.size() != 0 || exp_pc.size() != 0) && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (exp_req.size() != 0 || exp_pc.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d requests and %0d transfers outstanding expected 0", name, exp_req.size(), exp_pc.size());
      exp_req.delete();
      exp_pc.delete();
    end
  endtask

  task automatic test_reset();
    rst = 0;
    inst_ready = 1;
    stall_left = 0;
    drive_mem();
    step();
    step();
    tests++;
    if (imem_req_valid !== 0 || imem_resp_ready !== 0 || inst_valid !== 0) begin
      fails++;
      $display("FAIL reset_ctrl: got req=%b resp_rdy=%b inst_valid=%b expected 0 0 0", imem_req_valid, imem_resp_ready, inst_valid);
    end
    tests++;
    if (inst !== 0 || pc !== 0) begin
      fails++;
      $display("FAIL reset_data: got inst=%h pc=%h expected 0 0", inst, pc);
    end
    rst = 1;
    #1;
    tests++;
    if (imem_req_valid !== 1 || imem_req_addr !== R) begin
      fails++;
      $display("FAIL reset_fetch: got req=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, R);
    end
    rst = 0;
  endtask

  task automatic test_zero_wait();
    do_reset(0, 0);
    inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(R + 32'(4 * i));
      exp_pc.push_back(R + 32'(4 * i));
    end
    wait_done(30, "zero_wait");
    tests++;
    if (fire_cyc.size() != 3 || fire_cyc[0] - rel_cyc != 2 || fire_cyc[1] - fire_cyc[0] != 3 || fire_cyc[2] - fire_cyc[1] != 3) begin
      fails++;
      $display("FAIL zero_wait_timing: got %0d transfers first at +%0d expected 3 at +2 spaced 3", fire_cyc.size(), fire_cyc.size() > 0 ? fire_cyc[0] - rel_cyc : -1);
    end
  endtask

  task automatic test_stall();
    do_reset(4, 5);
    inst_ready = 1;
    exp_req.push_back(R);
    exp_pc.push_back(R);
    wait_done(40, "stall");
    stall_left = 1000;
    drive_mem();
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (req_cyc - rel_cyc != 4) begin
      fails++;
      $display("FAIL stall_accept: got accept at +%0d expected +4", req_cyc - rel_cyc);
    end
    tests++;
    if (fire_cyc.size() != 1 || fire_cyc[0] - req_cyc != 7) begin
      fails++;
      $display("FAIL stall_inst: got %0d transfers expected 1 at accept+7", fire_cyc.size());
    end
  endtask

  task automatic test_hold();
    do_reset(0, 0);
    exp_req.push_back(R);
    exp_req.push_back(R + 32'd4);
    exp_pc.push_back(R);
    for (int n = 0; n < 10 && !inst_valid; n++) step();
    tests++;
    if (inst_valid !== 1) begin
      fails++;
      $display("FAIL hold_reach: got inst_valid=%b expected 1", inst_valid);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (inst_valid !== 1 || pc !== R || inst !== memf(R) || imem_req_valid !== 0) begin
        fails++;
        $display("FAIL hold_stable: got v=%b pc=%h inst=%h req=%b expected 1 %h %h 0", inst_valid, pc, inst, imem_req_valid, R, memf(R));
      end
    end
    inst_ready = 1;
    wait_done(10, "hold_release");
  endtask

  task automatic test_redirect_wait();
    do_reset(0, 3);
    inst_ready = 1;
    exp_req.push_back(R);
    exp_req.push_back(32'h8000_0100);
    exp_pc.push_back(32'h8000_0100);
    for (int n = 0; n < 10 && !imem_resp_ready; n++) step();
    tests++;
    if (imem_resp_ready !== 1 || imem_resp_valid !== 0) begin
      fails++;
      $display("FAIL rdw_reach: got resp_rdy=%b resp_valid=%b expected 1 0", imem_resp_ready, imem_resp_valid);
    end
    redirect_valid = 1;
    redirect_pc = 32'h8000_0103;
    step();
    redirect_valid = 0;
    wait_done(30, "redirect_wait");
  endtask

  task automatic test_redirect_hold();
    do_reset(0, 0);
    exp_req.push_back(R);
    exp_req.push_back(32'h8000_0200);
    exp_pc.push_back(32'h8000_0200);
    for (int n = 0; n < 10 && !inst_valid; n++) step();
    redirect_valid = 1;
    redirect_pc = 32'h8000_0202;
    step();
    redirect_valid = 0;
    tests++;
    if (inst_valid !== 0) begin
      fails++;
      $display("FAIL rdh_drop: got inst_valid=%b expected 0", inst_valid);
    end
    inst_ready = 1;
    wait_done(20, "redirect_hold_drop");
    do_reset(0, 0);
    exp_req.push_back(R);
    exp_req.push_back(32'h8000_0300);
    exp_pc.push_back(R);
    exp_pc.push_back(32'h8000_0300);
    for (int n = 0; n < 10 && !inst_valid; n++) step();
    redirect_valid = 1;
    redirect_pc = 32'h8000_0301;
    inst_ready = 1;
    step();
    #1;
    tests++;
    if (imem_req_valid !== 0) begin
      fails++;
      $display("FAIL rdh_req_block: got req=%b expected 0", imem_req_valid);
    end
    step();
    redirect_valid = 0;
    wait_done(20, "redirect_hold_xfer");
  endtask

  task automatic test_reset_mid();
    do_reset(0, 4);
    inst_ready = 1;
    exp_req.push_back(R);
    for (int n = 0; n < 10 && !imem_resp_ready; n++) step();
    tests++;
    if (imem_resp_ready !== 1) begin
      fails++;
      $display("FAIL rst_reach: got resp_rdy=%b expected 1", imem_resp_ready);
    end
    rst = 0;
    step();
    tests++;
    if (imem_req_valid !== 0 || inst_valid !== 0 || imem_resp_ready !== 0) begin
      fails++;
      $display("FAIL rst_mid: got req=%b inst_valid=%b resp_rdy=%b expected 0 0 0", imem_req_valid, inst_valid, imem_resp_ready);
    end
    rst = 1;
    stall_left = 3;
    mem_busy = 1;
    mem_addr = 32'hdead_bee0;
    mem_cnt = 0;
    drive_mem();
    exp_req.push_back(R);
    exp_pc.push_back(R);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (imem_resp_ready !== 0 || inst_valid !== 0) begin
        fails++;
        $display("FAIL late_resp: got resp_rdy=%b inst_valid=%b expected 0 0", imem_resp_ready, inst_valid);
      end
      step();
    end
    mem_busy = 0;
    drive_mem();
    wait_done(20, "reset_restart");
  endtask

  // test sequence
  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_hold();
    test_redirect_wait();
    test_redirect_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the NPC core: owns the program counter, fetches 32-bit instructions from instruction memory over a valid/ready request/response interface, and presents each `inst` with its `pc` to the decode/execute stage over a valid/ready handshake. It is the producer side of the `inst`/`pc` pair the core consumes. It also accepts PC redirects from execute for branches and jumps, and squashes stale fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC fetched first after reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-low (`rst`=0 resets on the next `clk` edge).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address, always word-aligned.
- `imem_resp_valid`  in  1  response data valid.
- `imem_resp_ready`  out  1  ifu accepts response.
- `imem_resp_data`  in  32  fetched instruction word.
- `inst_valid`  out  1  `inst`/`pc` valid for consumer.
- `inst_ready`  in  1  consumer takes `inst`.
- `inst`  out  32  instruction word.
- `pc`  out  32  address of `inst`.
- `redirect_valid`  in  1  one-cycle redirect pulse from execute.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (treated as 0).

## Operation
- State machine, 3 states: REQ, WAIT, HOLD. Registers: `state`, `fetch_pc`, `squash`, `inst`, `pc`.
- REQ: `imem_req_valid` = !`redirect_valid`; `imem_req_addr` = `fetch_pc`. On `imem_req_valid && imem_req_ready` -> WAIT.
- WAIT: `imem_resp_ready`=1. On `imem_resp_valid`:
  - if `squash` or `redirect_valid`: drop data, clear `squash`, -> REQ.
  - else: `inst`<=`imem_resp_data`, `pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4 (mod 2^32, wraps), -> HOLD.
- HOLD: `inst_valid`=1, `inst`/`pc` stable. On `inst_ready` -> REQ.
- Redirect (`redirect_valid`=1), priority over sequential `fetch_pc`+4:
  - `fetch_pc` <= {`redirect_pc`[31:2], 2'b00} in every state.
  - REQ: no request is issued that cycle; state stays REQ.
  - WAIT without response that cycle: `squash`<=1 and state stays WAIT. The later response is dropped.
  - HOLD: -> REQ. If `inst_ready` is also 1, the transfer completes normally. Otherwise the held instruction is discarded and `inst_valid` falls next cycle.
- `imem_req_valid` must not drop once asserted unless a redirect arrives, which is the only permitted withdrawal.
- Only one request is ever outstanding.

## Timing
- Reset values: `state`=REQ, `fetch_pc`=`RESET_PC`, `squash`=0, `inst`=0, `pc`=0, `inst_valid`=0, `imem_resp_ready`=0.
- While `rst`=0: `imem_req_valid`=0.
- Reset asserted mid-fetch: any in-flight response is ignored by design, because state returns to REQ and `squash`=0. Memory must itself be reset alongside.
- Zero-wait memory (request accepted at cycle t, response at t+1):
  - `inst_valid` at t+2.
  - Next request at t+3 if `inst_ready` is 1 at t+2.
  - Throughput: 1 instruction per 3 cycles.
- Redirect at cycle t: the request carrying `redirect_pc` is issued at t+1 at the earliest.
- `imem_req_valid` depends combinationally on `redirect_valid`. All other outputs are registered or decoded from `state`.

## Structure
- Shared package `npc_pkg`:
  - `ifu_state_t` enum (REQ, WAIT, HOLD).
  - `NPC_RESET_PC` constant, used as the `RESET_PC` default.
  - `XLEN`=32.
- Single module. No sub-module; the PC update mux is a few lines inline.

## Test plan
- Reset, then zero-wait memory, `inst_ready`=1 -> first `imem_req_addr`=0x8000_0000; `inst`/`pc` pairs at 0x8000_0000, 0x8000_0004, 0x8000_0008, spaced 3 cycles apart.
- Memory stalls `imem_req_ready` for 4 cycles, then response delayed 5 cycles -> `imem_req_valid` and `imem_req_addr` held stable throughout; exactly one `inst_valid` with the correct data.
- `inst_ready`=0 for 6 cycles in HOLD -> `inst` and `pc` unchanged and no new request issued; next request goes out at `pc`+4 after the handshake.
- Redirect to 0x8000_0103 while in WAIT -> response for the old PC is dropped (no `inst_valid`); next `imem_req_addr`=0x8000_0100.
- Redirect in HOLD with `inst_ready`=0 -> held instruction never transferred; next fetch at the redirect target. Same case with `inst_ready`=1 -> held instruction transferred once.
- `rst` asserted for 1 cycle while in WAIT -> next cycle: `state`=REQ, `imem_req_valid`=0, `inst_valid`=0. After `rst` releases, fetch restarts at `RESET_PC`; a late response is ignored.
